// File: rtl/soc_pkg.sv
// Shared constants and types for the RAM dump arbiter slice.
package soc_pkg;

    localparam int AW = 17;
    localparam int DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } dump_state_t;

endpackage

// File: rtl/dump_out_reg.sv
// Single-entry output register for the dump stream with valid/ready hold.
module dump_out_reg #(
    parameter int AW = soc_pkg::AW,
    parameter int DW = soc_pkg::DW
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic [AW-1:0] load_addr,
    input  logic          ready,
    output logic          valid,
    output logic [DW-1:0] data,
    output logic [AW-1:0] addr
);

    // Load a fresh word, otherwise hold until the downstream accepts it.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            valid <= 1'b0;
            data  <= '0;
            addr  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            addr  <= load_addr;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_dump_arbiter.sv
// Shares the data RAM between the core (absolute priority) and a dump
// engine that streams an address range out over valid/ready in idle cycles.
module ram_dump_arbiter #(
    parameter int AW = soc_pkg::AW,
    parameter int DW = soc_pkg::DW
) (
    input  logic          clock,
    input  logic          nreset,
    input  logic [AW-1:0] core_addr,
    input  logic          core_ren,
    input  logic          core_wen,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_wen,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    input  logic          dump_start,
    input  logic [AW-1:0] dump_first,
    input  logic [AW-1:0] dump_last,
    output logic          dump_busy,
    output logic          dump_done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW-1:0] out_addr
);

    import soc_pkg::*;

    localparam logic [AW:0] ONE = (AW+1)'(1);

    dump_state_t   state;
    dump_state_t   state_next;
    logic [AW:0]   ptr;
    logic [AW:0]   rem;
    logic          inflight;
    logic [AW-1:0] issued_addr;
    logic          core_req;
    logic          issue;
    logic          range_ok;

    assign core_req   = core_ren | core_wen;
    assign range_ok   = (dump_last >= dump_first);
    assign core_rdata = ram_rdata;
    assign dump_busy  = (state != IDLE);
    assign dump_done  = (state == DONE);

    // ptr[AW] guards against the pointer ever running past the top address.
    assign issue = (state == RUN) && !core_req && !inflight &&
                   (!out_valid || out_ready) && (rem != '0) && !ptr[AW];

    // RAM port mux: core first, then dump read, else park on the core address.
    always_comb begin
        ram_addr  = core_addr;
        ram_wen   = 1'b0;
        ram_wdata = core_wdata;
        if (core_req) begin
            ram_wen = core_wen;
        end else if (issue) begin
            ram_addr = ptr[AW-1:0];
        end
    end

    // Dump sequencing: IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    state_next = range_ok ? RUN : DONE;
                end
            end
            RUN: begin
                if ((rem == '0) && !inflight && (!out_valid || out_ready)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Range latch at start, then pointer/remaining-count stepping per issued read.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            ptr         <= '0;
            rem         <= '0;
            inflight    <= 1'b0;
            issued_addr <= '0;
        end else begin
            inflight <= issue;
            if ((state == IDLE) && dump_start && range_ok) begin
                ptr <= {1'b0, dump_first};
                rem <= {1'b0, dump_last} - {1'b0, dump_first} + ONE;
            end else if (issue) begin
                ptr         <= ptr + ONE;
                rem         <= rem - ONE;
                issued_addr <= ptr[AW-1:0];
            end
        end
    end

    dump_out_reg #(
        .AW(AW),
        .DW(DW)
    ) u_out_reg (
        .clock     (clock),
        .nreset    (nreset),
        .load      (inflight),
        .load_data (ram_rdata),
        .load_addr (issued_addr),
        .ready     (out_ready),
        .valid     (out_valid),
        .data      (out_data),
        .addr      (out_addr)
    );

endmodule

// File: tb/tb_ram_dump_arbiter.sv
// Scoreboard bench for ram_dump_arbiter with a behavioural single-port RAM.
module tb_ram_dump_arbiter;

    import soc_pkg::*;

    logic          clock = 1'b0;
    logic          nreset = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic          core_ren = 1'b0;
    logic          core_wen = 1'b0;
    logic [DW-1:0] core_wdata = '0;
    logic [DW-1:0] core_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_wen;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic          dump_start = 1'b0;
    logic [AW-1:0] dump_first = '0;
    logic [AW-1:0] dump_last = '0;
    logic          dump_busy;
    logic          dump_done;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;

    ram_dump_arbiter #(
        .AW(AW),
        .DW(DW)
    ) dut (
        .clock      (clock),
        .nreset     (nreset),
        .core_addr  (core_addr),
        .core_ren   (core_ren),
        .core_wen   (core_wen),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .ram_addr   (ram_addr),
        .ram_wen    (ram_wen),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .dump_start (dump_start),
        .dump_first (dump_first),
        .dump_last  (dump_last),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_addr   (out_addr)
    );

    always #5 clock = ~clock;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    // Behavioural RAM: synchronous read, one-cycle latency.
    always @(posedge clock) begin
        if (ram_wen) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int            hs_q[$];
    int            done_q[$];
    int            vectors = 0;
    int            miscompares = 0;
    logic [AW-1:0] mon_a;
    logic [DW-1:0] mon_d;

    // Stream monitor: every accepted word is popped from the scoreboard.
    always @(negedge clock) begin
        if (nreset) begin
            if (out_valid && out_ready) begin
                hs_q.push_back(cyc);
                vectors++;
                if (exp_addr.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_extra: got addr %0d data %h, required no word", out_addr, out_data);
                end else begin
                    mon_a = exp_addr.pop_front();
                    mon_d = exp_data.pop_front();
                    if (out_addr !== mon_a || out_data !== mon_d) begin
                        miscompares++;
                        $display("FAIL stream_word: got addr %0d data %h, required addr %0d data %h",
                                 out_addr, out_data, mon_a, mon_d);
                    end
                end
            end
            if (dump_done) done_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_obs();
        hs_q.delete();
        done_q.delete();
    endtask

    task automatic start_dump(input int f, input int l, output int s0);
        dump_start = 1'b1;
        dump_first = AW'(f);
        dump_last  = AW'(l);
        for (int a = f; a <= l; a++) begin
            exp_addr.push_back(AW'(a));
            exp_data.push_back(ref_mem[a]);
        end
        s0 = cyc;
        tick();
        dump_start = 1'b0;
        dump_first = AW'($urandom);
        dump_last  = AW'($urandom);
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done_q.size() > 0) break;
            tick();
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        #3;
        vectors++;
        if ({out_valid, dump_busy, dump_done, ram_wen, out_addr, out_data} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid %b busy %b done %b wen %b addr %0d data %h, required all 0",
                     out_valid, dump_busy, dump_done, ram_wen, out_addr, out_data);
        end
        tick();
        tick();
        nreset = 1'b1;
        tick();
        vectors++;
        if ({out_valid, dump_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release: got valid %b busy %b, required 0 0", out_valid, dump_busy);
        end
    endtask

    task automatic test_basic();
        int s0;
        int e[4] = '{3, 5, 7, 9};
        int got;
        clear_obs();
        start_dump(10, 13, s0);
        wait_done(40);
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            got = (i < hs_q.size()) ? hs_q[i] - s0 : -1;
            vectors++;
            if (got != e[i]) begin
                miscompares++;
                $display("FAIL basic_hs_cycle[%0d]: got %0d, required %0d", i, got, e[i]);
            end
        end
        got = (done_q.size() == 1) ? done_q[0] - s0 : -1;
        vectors++;
        if (got != 10) begin
            miscompares++;
            $display("FAIL basic_done: got cycle %0d (count %0d), required cycle 10 once", got, done_q.size());
        end
    endtask

    task automatic test_core_stall();
        int s0;
        int rel;
        int got;
        int e[4] = '{3, 9, 11, 13};
        logic          prev_ren;
        logic [AW-1:0] prev_addr;
        prev_ren  = 1'b0;
        prev_addr = '0;
        clear_obs();
        start_dump(10, 13, s0);
        for (int k = 0; k < 40; k++) begin
            rel       = cyc - s0;
            core_ren  = (rel >= 2 && rel <= 6);
            core_addr = AW'(100 + rel);
            @(negedge clock);
            if (prev_ren) begin
                vectors++;
                if (core_rdata !== ref_mem[prev_addr]) begin
                    miscompares++;
                    $display("FAIL core_rdata@%0d: got %h, required %h", prev_addr, core_rdata, ref_mem[prev_addr]);
                end
            end
            prev_ren  = core_ren;
            prev_addr = core_addr;
            if (done_q.size() > 0) break;
            tick();
        end
        core_ren = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            got = (i < hs_q.size()) ? hs_q[i] - s0 : -1;
            vectors++;
            if (got != e[i]) begin
                miscompares++;
                $display("FAIL stall_hs_cycle[%0d]: got %0d, required %0d", i, got, e[i]);
            end
        end
        got = (done_q.size() == 1) ? done_q[0] - s0 : -1;
        vectors++;
        if (got != 14) begin
            miscompares++;
            $display("FAIL stall_done: got cycle %0d, required 14", got);
        end
    endtask

    task automatic test_backpressure();
        int s0;
        int rel;
        int got;
        int e[4] = '{9, 11, 13, 15};
        clear_obs();
        start_dump(30, 33, s0);
        for (int k = 0; k < 40; k++) begin
            rel       = cyc - s0;
            out_ready = !(rel >= 3 && rel <= 8);
            @(negedge clock);
            if (rel >= 3 && rel <= 8) begin
                vectors++;
                if ({out_valid, out_addr, out_data} !== {1'b1, AW'(30), ref_mem[30]}) begin
                    miscompares++;
                    $display("FAIL hold@%0d: got valid %b addr %0d data %h, required 1 30 %h",
                             rel, out_valid, out_addr, out_data, ref_mem[30]);
                end
            end
            if (done_q.size() > 0) break;
            tick();
        end
        out_ready = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            got = (i < hs_q.size()) ? hs_q[i] - s0 : -1;
            vectors++;
            if (got != e[i]) begin
                miscompares++;
                $display("FAIL bp_hs_cycle[%0d]: got %0d, required %0d", i, got, e[i]);
            end
        end
        got = (done_q.size() == 1) ? done_q[0] - s0 : -1;
        vectors++;
        if (got != 16) begin
            miscompares++;
            $display("FAIL bp_done: got cycle %0d, required 16", got);
        end
    endtask

    task automatic test_empty_and_single();
        int s0;
        int got;
        clear_obs();
        start_dump(20, 5, s0);
        @(negedge clock);
        vectors++;
        if ({dump_busy, dump_done} !== 2'b11) begin
            miscompares++;
            $display("FAIL empty_done: got busy %b done %b, required 1 1", dump_busy, dump_done);
        end
        tick();
        @(negedge clock);
        vectors++;
        if ({dump_busy, dump_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL empty_idle: got busy %b done %b, required 0 0", dump_busy, dump_done);
        end
        repeat (4) tick();
        vectors++;
        if (hs_q.size() != 0) begin
            miscompares++;
            $display("FAIL empty_words: got %0d words, required 0", hs_q.size());
        end

        clear_obs();
        start_dump(7, 7, s0);
        wait_done(20);
        repeat (4) tick();
        got = (hs_q.size() == 1) ? hs_q[0] - s0 : -1;
        vectors++;
        if (got != 3) begin
            miscompares++;
            $display("FAIL single_word: got hs cycle %0d (count %0d), required cycle 3 once", got, hs_q.size());
        end
        got = (done_q.size() == 1) ? done_q[0] - s0 : -1;
        vectors++;
        if (got != 4) begin
            miscompares++;
            $display("FAIL single_done: got cycle %0d, required 4", got);
        end
    endtask

    task automatic test_coherency();
        int s0;
        int rel;
        ref_mem[2] = 32'hDEADBEEF;
        clear_obs();
        start_dump(0, 3, s0);
        for (int k = 0; k < 40; k++) begin
            rel        = cyc - s0;
            core_wen   = (rel == 2);
            core_addr  = AW'(2);
            core_wdata = 32'hDEADBEEF;
            dump_start = (rel == 4);
            if (rel == 4) begin
                dump_first = AW'(40);
                dump_last  = AW'(45);
            end
            @(negedge clock);
            if (done_q.size() > 0) break;
            tick();
        end
        core_wen   = 1'b0;
        dump_start = 1'b0;
        repeat (10) tick();
        vectors++;
        if (hs_q.size() != 4 || done_q.size() != 1 || exp_addr.size() != 0) begin
            miscompares++;
            $display("FAIL coherency_count: got %0d words %0d done %0d pending, required 4 1 0",
                     hs_q.size(), done_q.size(), exp_addr.size());
        end
        vectors++;
        if (dump_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_ignored: got busy %b, required 0", dump_busy);
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        int got;
        clear_obs();
        start_dump(50, 53, s0);
        tick();
        tick();
        vectors++;
        if ({out_valid, out_addr} !== {1'b1, AW'(50)}) begin
            miscompares++;
            $display("FAIL pre_reset_valid: got valid %b addr %0d, required 1 50", out_valid, out_addr);
        end
        nreset = 1'b0;
        #1;
        vectors++;
        if ({out_valid, out_addr, out_data, dump_busy, dump_done} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got valid %b addr %0d data %h busy %b done %b, required all 0",
                     out_valid, out_addr, out_data, dump_busy, dump_done);
        end
        exp_addr.delete();
        exp_data.delete();
        tick();
        nreset = 1'b1;
        repeat (6) tick();
        vectors++;
        if (done_q.size() != 0 || hs_q.size() != 0) begin
            miscompares++;
            $display("FAIL mid_reset_quiet: got %0d done %0d words, required 0 0", done_q.size(), hs_q.size());
        end

        clear_obs();
        start_dump(60, 61, s0);
        wait_done(20);
        repeat (3) tick();
        got = (done_q.size() == 1) ? done_q[0] - s0 : -1;
        vectors++;
        if (hs_q.size() != 2 || got != 6) begin
            miscompares++;
            $display("FAIL post_reset_dump: got %0d words done cycle %0d, required 2 words done cycle 6",
                     hs_q.size(), got);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = 32'hC0DE0000 ^ (i * 32'h00019E37);
            ref_mem[i] = 32'hC0DE0000 ^ (i * 32'h00019E37);
        end
        test_reset();
        test_basic();
        test_core_stall();
        test_backpressure();
        test_empty_and_single();
        test_coherency();
        test_reset_mid();
        vectors++;
        if (exp_addr.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending words, required 0", exp_addr.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
